// File: rtl/regfile_pkg.sv
// Shared defaults and index helpers for the register file with a
// pending-write scoreboard.
package regfile_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_NUM_REGS   = 32;
   localparam int unsigned ZERO_REG_IDX   = 0;

   function automatic int unsigned addr_width_f(input int unsigned num_regs);
      return $clog2(num_regs);
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Write/read/reserve port bundle of regfile_scoreboard; the slave side is
// the register file, the master side the pipeline driving it.
interface regfile_scoreboard_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned ADDR_WIDTH = addr_width_f(NUM_REGS)
);

   logic                  ctrl_writeEnable;
   logic [ADDR_WIDTH-1:0] ctrl_writeReg;
   logic [DATA_WIDTH-1:0] data_writeReg;
   logic [ADDR_WIDTH-1:0] ctrl_readRegA;
   logic [ADDR_WIDTH-1:0] ctrl_readRegB;
   logic [DATA_WIDTH-1:0] data_readRegA;
   logic [DATA_WIDTH-1:0] data_readRegB;
   logic                  busyA;
   logic                  busyB;
   logic                  ctrl_reserveEnable;
   logic [ADDR_WIDTH-1:0] ctrl_reserveReg;
   logic                  reserve_ok;
   logic [ADDR_WIDTH:0]   pending_count;

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_readRegA, ctrl_readRegB,
      input  ctrl_reserveEnable, ctrl_reserveReg,
      output data_readRegA, data_readRegB, busyA, busyB,
      output reserve_ok, pending_count
   );

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_readRegA, ctrl_readRegB,
      output ctrl_reserveEnable, ctrl_reserveReg,
      input  data_readRegA, data_readRegB, busyA, busyB,
      input  reserve_ok, pending_count
   );

endinterface

// File: rtl/regfile_entry.sv
// One register: data word plus pending bit, both cleared by async reset.
// A reservation wins over the clear caused by a write in the same cycle.
module regfile_entry
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  set_pend_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  pend_o
);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  pend_q, pend_d;

   always_comb begin
      data_d = data_q;
      pend_d = pend_q;
      if (we_i) begin
         data_d = wdata_i;
         pend_d = 1'b0;
      end
      if (set_pend_i) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
         pend_q <= 1'b0;
      end else begin
         data_q <= data_d;
         pend_q <= pend_d;
      end
   end

   assign data_o = data_q;
   assign pend_o = pend_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with zero-latency bypassed reads and a per-register pending
// scoreboard; register 0 is hard-wired to zero and can never be reserved.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
   parameter int unsigned ADDR_WIDTH = addr_width_f(NUM_REGS)
) (
   input  logic                 clock,
   input  logic                 ctrl_reset,
   regfile_scoreboard_if.slave  rf_if
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(ZERO_REG_IDX);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
   logic [NUM_REGS-1:0]                 pend;

   logic                wr_valid;
   logic                byp_a, byp_b, byp_rsv;
   logic                rsv_ok;
   logic                rsv_new;
   logic                clr_live;
   logic [ADDR_WIDTH:0] count_q, count_d;

   assign regs[0] = '0;
   assign pend[0] = 1'b0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
      regfile_entry #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_entry (
         .clk_i      (clock),
         .rst_i      (ctrl_reset),
         .we_i       (wr_valid && (rf_if.ctrl_writeReg == ADDR_WIDTH'(i))),
         .wdata_i    (rf_if.data_writeReg),
         .set_pend_i (rsv_ok && (rf_if.ctrl_reserveReg == ADDR_WIDTH'(i))),
         .data_o     (regs[i]),
         .pend_o     (pend[i])
      );
   end

   // Writes are ignored while reset is held, which also blocks the bypass.
   assign wr_valid = !ctrl_reset && rf_if.ctrl_writeEnable &&
                     (rf_if.ctrl_writeReg != ZERO_REG);
   assign byp_a    = wr_valid && (rf_if.ctrl_writeReg == rf_if.ctrl_readRegA);
   assign byp_b    = wr_valid && (rf_if.ctrl_writeReg == rf_if.ctrl_readRegB);
   assign byp_rsv  = wr_valid && (rf_if.ctrl_writeReg == rf_if.ctrl_reserveReg);

   assign rf_if.data_readRegA = byp_a ? rf_if.data_writeReg : regs[rf_if.ctrl_readRegA];
   assign rf_if.data_readRegB = byp_b ? rf_if.data_writeReg : regs[rf_if.ctrl_readRegB];
   assign rf_if.busyA         = pend[rf_if.ctrl_readRegA] && !byp_a;
   assign rf_if.busyB         = pend[rf_if.ctrl_readRegB] && !byp_b;

   assign rsv_ok = !ctrl_reset && rf_if.ctrl_reserveEnable &&
                   (rf_if.ctrl_reserveReg != ZERO_REG) &&
                   (!pend[rf_if.ctrl_reserveReg] || byp_rsv);
   assign rf_if.reserve_ok = rsv_ok;

   // Count tracks only real bit transitions: a re-reserve of a pending
   // register, or a write cleared by a same-index reserve, leaves it alone.
   assign rsv_new  = rsv_ok && !pend[rf_if.ctrl_reserveReg];
   assign clr_live = wr_valid && pend[rf_if.ctrl_writeReg] && !(rsv_ok && byp_rsv);

   always_comb begin
      count_d = count_q;
      case ({rsv_new, clr_live})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign rf_if.pending_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, corner
// sequences and randomized traffic against an array-based reference model.
module tb_regfile_scoreboard;

   logic clk;
   logic rst;

   int checks   = 0;
   int failures = 0;

   regfile_scoreboard_if #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5)) bus ();

   regfile_scoreboard #(
      .DATA_WIDTH (32),
      .NUM_REGS   (32),
      .ADDR_WIDTH (5)
   ) dut (
      .clock      (clk),
      .ctrl_reset (rst),
      .rf_if      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural register contents and pending set.
   logic [31:0] m_regs [32];
   bit          m_pend [32];

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        re;
      logic [4:0]  rr;
      logic [31:0] dA;
      logic [31:0] dB;
      logic        bA;
      logic        bB;
      logic        ok;
      logic [5:0]  cnt;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic re, input logic [4:0] rr,
                               input logic [31:0] dA, input logic [31:0] dB,
                               input logic bA, input logic bB, input logic ok,
                               input logic [5:0] cnt);
      vec_t v;
      v.we = we; v.wr = wr; v.wd = wd; v.ra = ra; v.rb = rb; v.re = re; v.rr = rr;
      v.dA = dA; v.dB = dB; v.bA = bA; v.bB = bB; v.ok = ok; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic re, input logic [4:0] rr);
      bus.ctrl_writeEnable   = we;
      bus.ctrl_writeReg      = wr;
      bus.data_writeReg      = wd;
      bus.ctrl_readRegA      = ra;
      bus.ctrl_readRegB      = rb;
      bus.ctrl_reserveEnable = re;
      bus.ctrl_reserveReg    = rr;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
      return n;
   endfunction

   function automatic logic m_ok();
      logic wv = bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0);
      return bus.ctrl_reserveEnable && (bus.ctrl_reserveReg != 5'd0) &&
             (!m_pend[bus.ctrl_reserveReg] || (wv && bus.ctrl_writeReg == bus.ctrl_reserveReg));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.ctrl_writeEnable && bus.ctrl_writeReg == idx) return bus.data_writeReg;
      return m_regs[idx];
   endfunction

   function automatic logic m_busy(input logic [4:0] idx);
      if (idx == 5'd0) return 1'b0;
      if (bus.ctrl_writeEnable && bus.ctrl_writeReg == idx) return 1'b0;
      return m_pend[idx];
   endfunction

   // Apply the current inputs to the model as an edge: write first, then reserve.
   task automatic model_edge();
      logic ok;
      ok = m_ok();
      if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 5'd0) begin
         m_regs[bus.ctrl_writeReg] = bus.data_writeReg;
         m_pend[bus.ctrl_writeReg] = 1'b0;
      end
      if (ok) m_pend[bus.ctrl_reserveReg] = 1'b1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_dA"},  bus.data_readRegA, m_read(bus.ctrl_readRegA));
      chk({tag, "_dB"},  bus.data_readRegB, m_read(bus.ctrl_readRegB));
      chk({tag, "_bA"},  32'(bus.busyA), 32'(m_busy(bus.ctrl_readRegA)));
      chk({tag, "_bB"},  32'(bus.busyB), 32'(m_busy(bus.ctrl_readRegB)));
      chk({tag, "_ok"},  32'(bus.reserve_ok), 32'(m_ok()));
      chk({tag, "_cnt"}, 32'(bus.pending_count), 32'(model_count()));
   endtask

   task automatic model_cycle(input string tag, input logic we, input logic [4:0] wr,
                              input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                              input logic re, input logic [4:0] rr);
      @(negedge clk);
      drive(we, wr, wd, ra, rb, re, rr);
      #4;
      check_model(tag);
      @(posedge clk);
      model_edge();
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      model_reset();

      vecs[0]  = mk(0, 0,  32'h0,        0, 0, 0, 0,  32'h0,        32'h0,  0, 0, 0, 0);
      vecs[1]  = mk(1, 5,  32'hDEADBEEF, 5, 3, 0, 0,  32'hDEADBEEF, 32'h0,  0, 0, 0, 0);
      vecs[2]  = mk(0, 0,  32'h0,        5, 0, 0, 0,  32'hDEADBEEF, 32'h0,  0, 0, 0, 0);
      vecs[3]  = mk(1, 0,  32'h1234,     0, 0, 1, 0,  32'h0,        32'h0,  0, 0, 0, 0);
      vecs[4]  = mk(0, 0,  32'h0,        0, 7, 1, 7,  32'h0,        32'h0,  0, 0, 1, 0);
      vecs[5]  = mk(0, 0,  32'h0,        0, 7, 0, 0,  32'h0,        32'h0,  0, 1, 0, 1);
      vecs[6]  = mk(1, 7,  32'hA5,       0, 7, 0, 0,  32'h0,        32'hA5, 0, 0, 0, 1);
      vecs[7]  = mk(0, 0,  32'h0,        0, 7, 0, 0,  32'h0,        32'hA5, 0, 0, 0, 0);
      vecs[8]  = mk(0, 0,  32'h0,        9, 0, 1, 9,  32'h0,        32'h0,  0, 0, 1, 0);
      vecs[9]  = mk(0, 0,  32'h0,        9, 0, 1, 9,  32'h0,        32'h0,  1, 0, 0, 1);
      vecs[10] = mk(1, 9,  32'h55,       9, 0, 1, 9,  32'h55,       32'h0,  0, 0, 1, 1);
      vecs[11] = mk(0, 0,  32'h0,        9, 0, 0, 0,  32'h55,       32'h0,  1, 0, 0, 1);
      vecs[12] = mk(1, 9,  32'h66,       9, 3, 1, 3,  32'h66,       32'h0,  0, 0, 1, 1);
      vecs[13] = mk(0, 0,  32'h0,        9, 3, 0, 0,  32'h66,       32'h0,  0, 1, 0, 1);
      vecs[14] = mk(1, 5,  32'h77,       5, 3, 0, 0,  32'h77,       32'h0,  0, 1, 0, 1);
      vecs[15] = mk(1, 3,  32'h88,       3, 5, 0, 0,  32'h88,       32'h77, 0, 0, 0, 1);
      vecs[16] = mk(0, 0,  32'h0,        3, 5, 0, 0,  32'h88,       32'h77, 0, 0, 0, 0);

      // Reset state, with write and reserve attempts that must be ignored.
      @(negedge clk);
      drive(1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, 1'b1, 5'd5);
      #1;
      chk("rst_dA",  bus.data_readRegA, 32'd0);
      chk("rst_bA",  32'(bus.busyA), 32'd0);
      chk("rst_ok",  32'(bus.reserve_ok), 32'd0);
      chk("rst_cnt", 32'(bus.pending_count), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0);
      #1;
      chk("rst_nowrite", bus.data_readRegA, 32'd0);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].ra, vecs[i].rb, vecs[i].re, vecs[i].rr);
         #4;
         chk($sformatf("vec%0d_dA", i),  bus.data_readRegA, vecs[i].dA);
         chk($sformatf("vec%0d_dB", i),  bus.data_readRegB, vecs[i].dB);
         chk($sformatf("vec%0d_bA", i),  32'(bus.busyA), 32'(vecs[i].bA));
         chk($sformatf("vec%0d_bB", i),  32'(bus.busyB), 32'(vecs[i].bB));
         chk($sformatf("vec%0d_ok", i),  32'(bus.reserve_ok), 32'(vecs[i].ok));
         chk($sformatf("vec%0d_cnt", i), 32'(bus.pending_count), 32'(vecs[i].cnt));
         @(posedge clk);
         model_edge();
      end

      // Fill every reservable register, then confirm saturation.
      reset_dut();
      for (int i = 1; i < 32; i++) begin
         model_cycle("fill", 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 1'b1, 5'(i));
      end
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 5'd12, 5'd31, 1'b1, 5'd12);
      #4;
      chk("full_count",  32'(bus.pending_count), 32'd31);
      chk("full_refuse", 32'(bus.reserve_ok), 32'd0);
      chk("full_busyB",  32'(bus.busyB), 32'd1);
      @(posedge clk);
      model_edge();

      // Put data into a few registers, then assert reset between edges.
      model_cycle("pre", 1'b1, 5'd4, 32'h1111_2222, 5'd4, 5'd4, 1'b0, 5'd0);
      model_cycle("pre", 1'b0, 5'd0, 32'd0, 5'd4, 5'd12, 1'b0, 5'd0);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd12, 1'b1, 5'd20);
      #2;
      rst = 1'b1;
      drive(1'b1, 5'd7, 32'hABCD, 5'd4, 5'd7, 1'b1, 5'd7);
      #1;
      chk("midrst_dA",  bus.data_readRegA, 32'd0);
      chk("midrst_dB",  bus.data_readRegB, 32'd0);
      chk("midrst_bA",  32'(bus.busyA), 32'd0);
      chk("midrst_bB",  32'(bus.busyB), 32'd0);
      chk("midrst_ok",  32'(bus.reserve_ok), 32'd0);
      chk("midrst_cnt", 32'(bus.pending_count), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd4, 1'b0, 5'd0);
      model_reset();
      #1;
      chk("postrst_dA", bus.data_readRegA, 32'd0);
      chk("postrst_dB", bus.data_readRegB, 32'd0);

      for (int n = 0; n < 3000; n++) begin
         model_cycle("rnd",
                     1'($urandom_range(0, 2) == 0),
                     5'($urandom_range(0, 31)),
                     $urandom(),
                     5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 3) != 0),
                     5'($urandom_range(0, 31)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count; power of two, at least 4.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(NUM_REGS), register index width.
REQ-004 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port: ctrl_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: ctrl_writeEnable  input  1  write strobe.
REQ-007 SHALL have port: ctrl_writeReg  input  ADDR_WIDTH  write index.
REQ-008 SHALL have port: data_writeReg  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports: ctrl_readRegA, ctrl_readRegB  input  ADDR_WIDTH  read indices.
REQ-010 SHALL have ports: data_readRegA, data_readRegB  output  DATA_WIDTH  read data.
REQ-011 SHALL have ports: busyA, busyB  output  1  addressed register awaits a pending write.
REQ-012 SHALL have port: ctrl_reserveEnable  input  1  request to mark a destination pending.
REQ-013 SHALL have port: ctrl_reserveReg  input  ADDR_WIDTH  index to reserve.
REQ-014 SHALL have port: reserve_ok  output  1  reservation accepted this cycle.
REQ-015 SHALL have port: pending_count  output  ADDR_WIDTH+1  number of pending registers.

Function
REQ-016 SHALL store a write when ctrl_writeEnable=1 and ctrl_writeReg!=0; it is visible in storage from the next edge.
REQ-017 SHALL hard-wire register 0: reads return 0, writes ignored, never pending, never busy.
REQ-018 SHALL drive read ports combinationally with zero latency, using muxes, not tri-state buses.
REQ-019 SHALL bypass: when a valid write targets the read index in the same cycle, data_readRegX = data_writeReg.
REQ-020 SHALL keep one pending bit per register; a valid write to register i clears pending[i] at the edge.
REQ-021 SHALL set reserve_ok = ctrl_reserveEnable and (ctrl_reserveReg!=0) and (pending[ctrl_reserveReg]=0 or a write to the same index this cycle).
REQ-022 SHALL set pending[ctrl_reserveReg] at the edge when reserve_ok=1; reserve takes priority over the clear of the same index.
REQ-023 SHALL leave all state unchanged on a refused reservation (reserve_ok=0).
REQ-024 SHALL drive busyX = pending[ctrl_readRegX] and not (valid write to ctrl_readRegX this cycle).
REQ-025 SHALL update pending_count each edge: +1 on reserve_ok without clear of another pending register; -1 on clear without reserve; unchanged when both or neither occur.
REQ-026 SHALL keep pending_count equal to the population count of pending bits at all times and never exceed NUM_REGS-1.
REQ-027 SHALL treat a write to a non-pending register as a normal write, with no count change.

Reset
REQ-028 SHALL on ctrl_reset=1, independent of clock, clear all registers to 0, all pending bits to 0, and pending_count to 0.
REQ-029 SHALL during reset drive busyA=busyB=0 and reserve_ok=0, ignore writes and reservations, and drive reads of stored values as 0.
REQ-030 SHALL resume normal operation on the first rising edge after ctrl_reset deasserts.

Structure
REQ-031 SHALL take DATA_WIDTH and NUM_REGS defaults from shared package regfile_pkg.
REQ-032 SHALL place the ADDR_WIDTH derivation and the zero-register index constant in regfile_pkg.
REQ-033 SHALL implement each entry (data word plus pending bit, async reset) as sub-module regfile_entry, instantiated NUM_REGS-1 times.

Verification
REQ-034 SHALL cover: write r5=0xDEADBEEF; next cycle read A=5 -> 0xDEADBEEF, busyA=0.
REQ-035 SHALL cover: write r0=0x1234 and reserve r0 -> read r0=0, reserve_ok=0, pending_count=0.
REQ-036 SHALL cover: reserve r7 -> pending_count=1, busyB=1 on reading r7; write r7=0xA5 with read B=7 in the same cycle -> data_readRegB=0xA5, busyB=0; next cycle pending_count=0.
REQ-037 SHALL cover: r9 pending, reserve r9 again with no write -> reserve_ok=0, count unchanged; reserve r9 while writing r9 -> reserve_ok=1, pending stays 1, count unchanged.
REQ-038 SHALL cover: reserve r1..r31 -> pending_count=31; further reserves refused.
REQ-039 SHALL cover: assert ctrl_reset mid-sequence between edges -> all reads 0, busy 0, count 0 immediately.
